// File: rtl/dmem_req_responder_if.sv
// Request/response channel bundle between a MEM-stage master and the dmem responder.
interface dmem_req_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_req_responder.sv
// Word-organised data RAM answering one load/store per request after WAIT_STATES extra cycles.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range word index flags rsp_err instead of wrapping).
module dmem_req_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_req_responder_if.slave  bus_io
);
  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            ready_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;
  logic            wr_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            oob_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   idx_s;
  logic            oob_s;
  logic            commit_s;

  // Word index of the incoming request and whether it falls outside the RAM.
  always_comb begin
    idx_s = AW'((bus_io.req_addr - BASE_ADDR) >> 2'd2);
`ifdef DMEM_RANGE_CHECK_EN
    oob_s = (((bus_io.req_addr - BASE_ADDR) >> 2'd2) >= 32'(DEPTH_WORDS));
`else
    oob_s = 1'b0;
`endif
  end

  // The store commits on the same edge that moves the FSM into RESP; reset forces IDLE so an
  // aborted store can never reach the RAM.
  assign commit_s = (state_q == ST_WAIT) && (cnt_q == 4'd0) && wr_q && !oob_q;

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'b0000;
      oob_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus_io.req_valid && ready_q) begin
            wr_q    <= bus_io.req_write;
            idx_q   <= idx_s;
            wdata_q <= bus_io.req_wdata;
            be_q    <= bus_io.req_be;
            oob_q   <= oob_s;
            cnt_q   <= WAIT_INIT;
            ready_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= oob_q;
            rsp_rdata_q <= (wr_q || oob_q) ? 32'h0000_0000 : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus_io.rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
      endcase
    end
  end

  // Byte-enabled RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  assign bus_io.req_ready = ready_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;
  assign bus_io.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_req_responder.sv
// Scoreboard bench: three responders (WAIT_STATES 1, 0, 3) driven by directed and random traffic.
module tb_dmem_req_responder;
  localparam int NI = 3;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    longint      t_acc;
  } exp_t;

  logic        clk;
  logic        rst_n     [NI];
  logic        req_valid [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [31:0] req_wdata [NI];
  logic [3:0]  req_be    [NI];
  logic        rsp_ready [NI];
  logic        req_ready_w [NI];
  logic        rsp_valid_w [NI];
  logic [31:0] rsp_rdata_w [NI];
  logic        rsp_err_w   [NI];

  int          checks;
  int          failures;
  exp_t        exp_q[$];
  exp_t        cur   [NI];
  logic        prev_v[NI];
  logic [31:0] ref_mem [NI][256];

  dmem_req_responder_if bus [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bus[g].req_valid = req_valid[g];
    assign bus[g].req_write = req_write[g];
    assign bus[g].req_addr  = req_addr[g];
    assign bus[g].req_wdata = req_wdata[g];
    assign bus[g].req_be    = req_be[g];
    assign bus[g].rsp_ready = rsp_ready[g];
    assign req_ready_w[g]   = bus[g].req_ready;
    assign rsp_valid_w[g]   = bus[g].rsp_valid;
    assign rsp_rdata_w[g]   = bus[g].rsp_rdata;
    assign rsp_err_w[g]     = bus[g].rsp_err;

    dmem_req_responder #(
      .DEPTH_WORDS(256),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
      .BASE_ADDR  (32'h0000_0000)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .bus_io(bus[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h required=%h t=%0t", nm, k, act, req, $time);
    end
  endtask

  // Reference model: applies a request to the per-instance byte-addressed word array.
  function automatic exp_t model_apply(input int k, input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wd, input logic [3:0] be);
    exp_t        e;
    logic [31:0] widx;
    int          slot;
    widx    = addr / 32'd4;
    e.k     = k;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    e.t_acc = 0;
`ifdef DMEM_RANGE_CHECK_EN
    if (widx >= 32'd256) begin
      e.err = 1'b1;
      return e;
    end
`endif
    slot = int'(widx % 32'd256);
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ref_mem[k][slot][8*b +: 8] = wd[8*b +: 8];
      end
    end else begin
      e.rdata = ref_mem[k][slot];
    end
    return e;
  endfunction

  task automatic scramble(input int k);
    req_valid[k] = 1'($urandom_range(0, 1));
    req_write[k] = 1'($urandom_range(0, 1));
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;
    req_be[k]    = 4'($urandom_range(0, 15));
  endtask

  // One transaction: bp = cycles of response backpressure, abort = pulse reset one cycle after accept.
  task automatic do_txn(input int k, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int bp, input bit abort);
    bit     acc;
    bit     seen;
    int     n;
    longint t_acc;
    exp_t   e;
    @(posedge clk); #1;
    req_write[k] = wr; req_addr[k] = addr; req_wdata[k] = wd; req_be[k] = be;
    req_valid[k] = 1'b1; rsp_ready[k] = 1'b0;
    acc = 1'b0; t_acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = req_ready_w[k];
      @(posedge clk); t_acc = longint'($time);
    end
    if (!acc) begin
      check("accept_timeout", k, 32'd0, 32'd1);
      #1 req_valid[k] = 1'b0;
      return;
    end
    #1 scramble(k);
    if (abort) begin
      @(posedge clk); #1;
      rst_n[k] = 1'b0; req_valid[k] = 1'b0;
      #1;
      check("rst_rsp_valid", k, {31'd0, rsp_valid_w[k]}, 32'd0);
      check("rst_rsp_rdata", k, rsp_rdata_w[k], 32'd0);
      check("rst_rsp_err",   k, {31'd0, rsp_err_w[k]}, 32'd0);
      check("rst_req_ready", k, {31'd0, req_ready_w[k]}, 32'd1);
      @(posedge clk); #1 rst_n[k] = 1'b1;
      @(negedge clk);
      check("post_rst_ready", k, {31'd0, req_ready_w[k]}, 32'd1);
      return;
    end
    e = model_apply(k, wr, addr, wd, be);
    e.t_acc = t_acc;
    exp_q.push_back(e);
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk); seen = rsp_valid_w[k]; n++;
    end
    if (!seen) begin
      check("rsp_timeout", k, 32'd0, 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1 scramble(k);
      @(negedge clk);
      check("bp_req_ready", k, {31'd0, req_ready_w[k]}, 32'd0);
      check("bp_rsp_valid", k, {31'd0, rsp_valid_w[k]}, 32'd1);
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
    @(posedge clk); #1 rsp_ready[k] = 1'b0;
    @(negedge clk);
    check("hs_rsp_valid", k, {31'd0, rsp_valid_w[k]}, 32'd0);
    check("hs_req_ready", k, {31'd0, req_ready_w[k]}, 32'd1);
  endtask

  // Monitor: pops the scoreboard on each new response and checks stability while held.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst_n[k] && rsp_valid_w[k]) begin
        if (!prev_v[k]) begin
          if (exp_q.size() == 0 || exp_q[0].k != k) begin
            check("unexpected_rsp", k, 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            cur[k] <= e;
            check("rsp_rdata", k, rsp_rdata_w[k], e.rdata);
            check("rsp_err", k, {31'd0, rsp_err_w[k]}, {31'd0, e.err});
            check("rsp_latency", k, 32'(longint'($time) - 64'd5 - e.t_acc),
                  32'((1 + ws_of(k)) * 10));
          end
        end else begin
          check("hold_rdata", k, rsp_rdata_w[k], cur[k].rdata);
          check("hold_err", k, {31'd0, rsp_err_w[k]}, {31'd0, cur[k].err});
        end
      end
      prev_v[k] <= rst_n[k] && rsp_valid_w[k];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog inst=-1 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    checks = 0; failures = 0;
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_be[k] = 4'h0; rsp_ready[k] = 1'b0; prev_v[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset_req_ready", k, {31'd0, req_ready_w[k]}, 32'd1);
      check("reset_rsp_valid", k, {31'd0, rsp_valid_w[k]}, 32'd0);
      check("reset_rsp_rdata", k, rsp_rdata_w[k], 32'd0);
      check("reset_rsp_err",   k, {31'd0, rsp_err_w[k]}, 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

    // Known contents in words 0..15 of every instance.
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 16; w++)
        do_txn(k, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, 1'b0);

    do_txn(0, 1'b1, 32'h0000_0004, 32'hAABB_CCDD, 4'b1111, 0, 1'b0);
    do_txn(0, 1'b0, 32'h0000_0004, 32'h0, 4'b0000, 0, 1'b0);
    do_txn(0, 1'b1, 32'h0000_0010, 32'h0000_0000, 4'b1111, 0, 1'b0);
    do_txn(0, 1'b1, 32'h0000_0012, 32'h00A5_0000, 4'b0100, 0, 1'b0);
    do_txn(0, 1'b1, 32'h0000_0010, 32'h0000_0011, 4'b0001, 0, 1'b0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 3, 1'b0);
    do_txn(1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, 1'b0);
    do_txn(1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 0, 1'b0);
    do_txn(1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 1, 1'b0);
    do_txn(0, 1'b1, 32'h0000_0400, 32'h1234_5678, 4'b1111, 0, 1'b0);
    do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 4'b0000, 0, 1'b0);
    do_txn(2, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'b1111, 0, 1'b1);
    do_txn(2, 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 0, 1'b0);

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 30; i++) begin
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) + $urandom_range(0, 3) * 1024);
        do_txn(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", -1, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
